// File: rtl/sw_operand_capture_pkg.sv
// Shared constants for the switch operand capture path: load-FSM encoding
// and the debounce counter width.
package sw_operand_capture_pkg;

  localparam int DB_CNT_W = 20;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_RELWAIT = 2'd2
  } load_state_t;

endpackage

// File: rtl/sw_operand_capture_db_filter.sv
// Single-bit 2-flop synchronizer plus counting debouncer. The debounced level
// only moves after DB_CYCLES consecutive clocks of disagreement.
module db_filter
  import sw_operand_capture_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_CYCLES - 1);

  logic                meta;
  logic                x_s;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      x_s  <= 1'b0;
      db   <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      x_s  <= meta;
      // Any return to the current level restarts the stability count.
      if (x_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= x_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_operand_capture.sv
// Debounces eight switches and a load button, then latches the switch value
// as two 4-bit operands once per debounced press.
module sw_operand_capture
  import sw_operand_capture_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_load,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       load_pulse,
  output logic       valid,
  output logic [7:0] sw_db,
  output logic [1:0] fsm_state
);

  logic [8:0]  raw_in;
  logic [8:0]  db_all;
  logic        btn_db;
  load_state_t state;

  assign raw_in = {btn_load, sw};

  for (genvar i = 0; i < 9; i++) begin : g_db
    db_filter #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .db   (db_all[i])
    );
  end

  assign sw_db     = db_all[7:0];
  assign btn_db    = db_all[8];
  assign fsm_state = state;

  // Outputs are registered on entry to PRESSED so they appear with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_a       <= 4'h0;
      op_b       <= 4'h0;
      load_pulse <= 1'b0;
      valid      <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn_db) begin
            state      <= S_PRESSED;
            op_a       <= sw_db[3:0];
            op_b       <= sw_db[7:4];
            load_pulse <= 1'b1;
            valid      <= 1'b1;
          end
        end
        S_PRESSED: state <= S_RELWAIT;
        S_RELWAIT: if (!btn_db) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_operand_capture.sv
// Directed bench for sw_operand_capture with DB_CYCLES = 4: table of
// press/bounce steps plus hand-written latency and reset sequences.
module tb_sw_operand_capture;
  import sw_operand_capture_pkg::*;

  localparam int DBC = 4;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic       btn_load;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       load_pulse;
  logic       valid;
  logic [7:0] sw_db;
  logic [1:0] fsm_state;

  sw_operand_capture #(.DB_CYCLES(DBC)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_load  (btn_load),
    .op_a      (op_a),
    .op_b      (op_b),
    .load_pulse(load_pulse),
    .valid     (valid),
    .sw_db     (sw_db),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_seen = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every load strobe must match the next expected {op_b, op_a}
  always @(negedge clk) begin
    if (reset && load_pulse) begin
      pulse_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: got ops %0h expected no load", {op_b, op_a});
      end else begin
        check("load_ops", {24'h0, op_b, op_a}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [7:0] sw;
    logic       btn;
    int         cycles;
    int         loads;
    logic [7:0] sw_db;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       valid;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    // press 20, release, bounced press, bounced release, new switch value,
    // simultaneous switch change with press (held into the reset test)
    vecs[0]  = '{8'h3A, 1'b1, 20, 1, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[1]  = '{8'h3A, 1'b0, 10, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[2]  = '{8'h3A, 1'b1,  2, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[3]  = '{8'h3A, 1'b0,  1, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[4]  = '{8'h3A, 1'b1,  3, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[5]  = '{8'h3A, 1'b0,  2, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[6]  = '{8'h3A, 1'b1, 20, 1, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[7]  = '{8'h3A, 1'b0,  3, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[8]  = '{8'h3A, 1'b1,  1, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[9]  = '{8'h3A, 1'b0,  2, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[10] = '{8'h3A, 1'b1,  3, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[11] = '{8'h3A, 1'b0, 12, 0, 8'h3A, 4'hA, 4'h3, 1'b1};
    vecs[12] = '{8'hF7, 1'b0, 10, 0, 8'hF7, 4'hA, 4'h3, 1'b1};
    vecs[13] = '{8'hF7, 1'b1, 20, 1, 8'hF7, 4'h7, 4'hF, 1'b1};
    vecs[14] = '{8'hF7, 1'b0, 12, 0, 8'hF7, 4'h7, 4'hF, 1'b1};
    vecs[15] = '{8'h5C, 1'b1, 20, 1, 8'h5C, 4'hC, 4'h5, 1'b1};

    // reset held with switches high
    reset    = 1'b0;
    sw       = 8'hFF;
    btn_load = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("reset_hold", {14'h0, op_b, op_a, sw_db, valid, load_pulse}, 32'h0);
    end
    sw = 8'h00;
    tick(1);
    reset = 1'b1;
    tick(4);

    // switch debounce latency: new level visible after edge 6 only
    sw = 8'h3A;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("db_latency", {24'h0, sw_db}, (k >= 6) ? 32'h3A : 32'h00);
    end

    // 3-cycle glitch on sw[0] must not propagate
    sw = 8'h3B;
    tick(3);
    sw = 8'h3A;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch", {24'h0, sw_db}, 32'h3A);
    end
    check("valid_before_load", {31'h0, valid}, 32'h0);

    // table-driven press/release steps
    for (int v = 0; v < NV; v++) begin
      int start;
      sw       = vecs[v].sw;
      btn_load = vecs[v].btn;
      if (vecs[v].loads != 0) exp_q.push_back({vecs[v].op_b, vecs[v].op_a});
      start = pulse_seen;
      tick(vecs[v].cycles);
      check($sformatf("step%0d_loads", v), pulse_seen - start, vecs[v].loads);
      check($sformatf("step%0d_outs", v), {15'h0, sw_db, op_b, op_a, valid},
            {15'h0, vecs[v].sw_db, vecs[v].op_b, vecs[v].op_a, vecs[v].valid});
    end

    // asynchronous reset while holding the button in RELEASE_WAIT
    check("in_relwait", 32'(fsm_state), 32'(S_RELWAIT));
    #2 reset = 1'b0;
    #1;
    check("async_clear", {14'h0, op_b, op_a, sw_db, valid, load_pulse}, 32'h0);
    check("async_idle", 32'(fsm_state), 32'(S_IDLE));
    tick(3);
    reset = 1'b1;
    exp_q.push_back(8'h5C);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("rst_reload_pulse", {31'h0, load_pulse}, (k == 7) ? 32'h1 : 32'h0);
      check("rst_reload_valid", {31'h0, valid}, (k >= 7) ? 32'h1 : 32'h0);
    end
    btn_load = 1'b0;
    tick(12);
    check("final_ops", {24'h0, op_b, op_a}, 32'h5C);
    check("exp_q_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_operand_capture.md
# sw_operand_capture

Upstream input stage for the switch-driven hex adder/display path. It synchronizes and debounces the eight slide switches and a load push-button, then latches the debounced switch value as two 4-bit operands on each debounced button press. Its `op_a`/`op_b` outputs feed the adder operands in place of raw `sw[3:0]`/`sw[7:4]`. The `valid` flag gates display of the sum.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable clocks required before a debounced level changes (10 ms at 50 MHz). Legal range is 2 to 2^20-1.
- `clk` input, 1 bit: system clock. All state is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Asserted at 0.
- `sw` input, 8 bits: raw slide switches. Asynchronous to `clk`.
- `btn_load` input, 1 bit: raw load push-button, active-high. Asynchronous to `clk`.
- `op_a` output, 4 bits: latched operand A, equal to debounced `sw[3:0]` at the last load.
- `op_b` output, 4 bits: latched operand B, equal to debounced `sw[7:4]` at the last load.
- `load_pulse` output, 1 bit: single-cycle strobe in the cycle the new operands first appear.
- `valid` output, 1 bit: high from the first load until reset.
- `sw_db` output, 8 bits: live debounced switch levels, for LED echo.

## Operation
- Each of the 9 raw inputs (8 switches plus the button) passes through a 2-flop synchronizer giving `x_s`.
- **Per-input debouncer:**
  - Holds `db` and a 20-bit counter `cnt`.
  - If `x_s == db`, then `cnt <= 0`.
  - Otherwise, if `cnt == DB_CYCLES-1`, then `db <= x_s` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt + 1`.
  - Any glitch back to `db` restarts the count, so pulses shorter than `DB_CYCLES` never propagate.
- **Load FSM** on the debounced button `btn_db`, with states IDLE, PRESSED and RELEASE_WAIT:
  - IDLE: when `btn_db` = 1, go to PRESSED.
  - PRESSED (one cycle):
    - `op_a <= sw_db[3:0]`, `op_b <= sw_db[7:4]`.
    - `load_pulse` = 1, `valid <= 1`.
    - Go to RELEASE_WAIT.
  - RELEASE_WAIT: when `btn_db` = 0, go to IDLE.
  - Holding the button produces exactly one load. A new load requires a debounced release followed by a debounced press.
- The operands are the `sw_db` values in the PRESSED cycle. Switches still bouncing at that moment contribute their prior debounced level.
- Operands hold indefinitely between loads. There is no arithmetic in this block; the downstream adder zero-extends `op_a` and `op_b` to 8 bits.

## Timing
- **Reset values:**
  - Synchronizers, `db`, `cnt`: 0.
  - `op_a`, `op_b`: 4'h0.
  - `load_pulse`, `valid`: 0.
  - `sw_db`: 8'h00.
  - FSM: IDLE.
- **Input latency:** a clean pin transition sampled at edge 0 appears in `x_s` after edge 2. `db` (and therefore `sw_db`) updates at edge 2+`DB_CYCLES`.
- **Load latency:** `btn_db` rises at edge N, FSM enters PRESSED at edge N+1, and `load_pulse`, `op_a` and `op_b` are visible in the cycle after edge N+1.
- `load_pulse` is high for exactly one clock per press.
- **Simultaneous switch change and press:** the operands take the debounced values at edge N+1.
- **Reset asserted mid-count or mid-press:** all state clears immediately with no clock required. After deassertion, a button still held at 1 debounces from 0 and yields one fresh load.
- The counter never wraps: the bound `DB_CYCLES-1` is always reached first.

## Structure
- Shared package or header holds:
  - The load-FSM state encoding (2-bit localparams `S_IDLE`, `S_PRESSED`, `S_RELWAIT`).
  - The counter width `DB_CNT_W = 20`.
- One sub-module, `db_filter`, contains the synchronizer, counter and `db` register for a single bit. Instantiate it 9 times via generate.

## Test plan
Run with `DB_CYCLES = 4` throughout.
1. **Reset:** hold `reset` = 0 with `sw` = 8'hFF. Required: `op_a` = 0, `op_b` = 0, `valid` = 0, `load_pulse` = 0 and `sw_db` = 0 throughout.
2. **Switch debounce:** set `sw` = 8'h3A cleanly at edge 0. Required: `sw_db` = 8'h3A after edge 6 and not before.
3. **Glitch rejection:** pulse `sw[0]` high for 3 cycles. Required: `sw_db[0]` stays 0.
4. **Basic load:** with `sw` = 8'h3A settled, press `btn_load` for 20 cycles. Required: exactly one `load_pulse`, then `op_a` = 4'hA, `op_b` = 4'h3, `valid` = 1.
5. **Hold and retrigger:** press while holding, with bounces of 1–3 cycles on press and release. Required: one `load_pulse` per debounced press. Then change `sw` to 8'hF7 and press again. Required: `op_a` = 4'h7, `op_b` = 4'hF.
6. **Mid-press reset:** assert `reset` while in RELEASE_WAIT. Required: outputs clear immediately. Release `reset` with the button still held. Required: one new load occurs 2+4+1 cycles later.
